// File: rtl/i2c_register_bridge.sv
// I2C slave front end for the FPGA register file: address match, auto-increment pointer, byte writes and reads.
// Define I2C_BRIDGE_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter on SCL/SDA.
module i2c_register_bridge #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h3C,
    parameter int         FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out_en,
    output logic [7:0] reg_addr,
    output logic [7:0] data_to_reg,
    output logic       write_en,
    input  logic [7:0] data_from_reg,
    output logic       busy
);

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_len_check
        $error("FILTER_LEN must be in the range 2..15");
    end

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_DEV,
        WR_PTR,
        WR_DATA,
        ACK_W,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_lvl;
    logic       sda_lvl;
    logic       scl_prev;
    logic       sda_prev;

    // Idle bus is high; resetting to 1 avoids phantom edges after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_BRIDGE_GLITCH_FILTER_EN
    logic [3:0] scl_cnt;
    logic [3:0] sda_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_lvl <= 1'b1;
            sda_lvl <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_lvl) begin
                scl_cnt <= '0;
            end else if (scl_cnt == 4'(FILTER_LEN - 1)) begin
                scl_lvl <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_sync[1] == sda_lvl) begin
                sda_cnt <= '0;
            end else if (sda_cnt == 4'(FILTER_LEN - 1)) begin
                sda_lvl <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end
`else
    assign scl_lvl = scl_sync[1];
    assign sda_lvl = sda_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_lvl;
            sda_prev <= sda_lvl;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  = scl_lvl & ~scl_prev;
    assign scl_fall  = ~scl_lvl & scl_prev;
    assign sda_rise  = sda_lvl & ~sda_prev;
    assign sda_fall  = ~sda_lvl & sda_prev;
    assign start_det = sda_fall & scl_lvl & scl_prev;
    assign stop_det  = sda_rise & scl_lvl & scl_prev;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] bit_cnt;
    logic [3:0] bit_cnt_nxt;
    logic       phase;
    logic       phase_nxt;
    logic [7:0] shreg;
    logic [7:0] shreg_nxt;
    logic       rw;
    logic       rw_nxt;
    logic       wr_pend;
    logic       wr_pend_nxt;
    logic       oe_nxt;
    logic [7:0] addr_nxt;
    logic [7:0] data_nxt;
    logic       we_nxt;
    logic       busy_nxt;
    logic [7:0] rx_byte;

    assign rx_byte = {shreg[6:0], sda_lvl};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            phase       <= 1'b0;
            shreg       <= '0;
            rw          <= 1'b0;
            wr_pend     <= 1'b0;
            sda_out_en  <= 1'b0;
            reg_addr    <= '0;
            data_to_reg <= '0;
            write_en    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            phase       <= phase_nxt;
            shreg       <= shreg_nxt;
            rw          <= rw_nxt;
            wr_pend     <= wr_pend_nxt;
            sda_out_en  <= oe_nxt;
            reg_addr    <= addr_nxt;
            data_to_reg <= data_nxt;
            write_en    <= we_nxt;
            busy        <= busy_nxt;
        end
    end

    // phase splits each ACK slot: 0 = before the 8th fall, 1 = driving until the 9th fall.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        phase_nxt   = phase;
        shreg_nxt   = shreg;
        rw_nxt      = rw;
        wr_pend_nxt = wr_pend;
        oe_nxt      = sda_out_en;
        addr_nxt    = write_en ? reg_addr + 8'd1 : reg_addr;
        data_nxt    = data_to_reg;
        we_nxt      = 1'b0;
        busy_nxt    = busy;

        if (start_det) begin
            state_nxt   = DEV_ADDR;
            bit_cnt_nxt = '0;
            phase_nxt   = 1'b0;
            wr_pend_nxt = 1'b0;
            oe_nxt      = 1'b0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            phase_nxt   = 1'b0;
            wr_pend_nxt = 1'b0;
            oe_nxt      = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            unique case (state)
                IDLE, WAIT_STOP: begin
                    oe_nxt = 1'b0;
                end
                DEV_ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
                            rw_nxt      = sda_lvl;
                            phase_nxt   = 1'b0;
                            if (rx_byte[7:1] == DEVICE_ADDRESS) begin
                                state_nxt = ACK_DEV;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = WAIT_STOP;
                                busy_nxt  = 1'b0;
                            end
                        end
                    end
                end
                ACK_DEV: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            oe_nxt    = 1'b1;
                            phase_nxt = 1'b1;
                        end else begin
                            phase_nxt = 1'b0;
                            if (rw) begin
                                state_nxt = RD_DATA;
                                shreg_nxt = {data_from_reg[6:0], 1'b0};
                                oe_nxt    = ~data_from_reg[7];
                            end else begin
                                state_nxt = WR_PTR;
                                oe_nxt    = 1'b0;
                            end
                        end
                    end
                end
                WR_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
                            phase_nxt   = 1'b0;
                            state_nxt   = ACK_W;
                            if (state == WR_PTR) begin
                                addr_nxt    = rx_byte;
                                wr_pend_nxt = 1'b0;
                            end else begin
                                data_nxt    = rx_byte;
                                wr_pend_nxt = 1'b1;
                            end
                        end
                    end
                end
                ACK_W: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            oe_nxt      = 1'b1;
                            phase_nxt   = 1'b1;
                            we_nxt      = wr_pend;
                            wr_pend_nxt = 1'b0;
                        end else begin
                            oe_nxt    = 1'b0;
                            phase_nxt = 1'b0;
                            state_nxt = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_nxt      = 1'b0;
                            bit_cnt_nxt = '0;
                            phase_nxt   = 1'b0;
                            state_nxt   = RD_ACK;
                        end else begin
                            oe_nxt    = ~shreg[7];
                            shreg_nxt = {shreg[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (!phase) begin
                        if (scl_rise) begin
                            addr_nxt = reg_addr + 8'd1;
                            if (sda_lvl) begin
                                state_nxt = WAIT_STOP;
                                busy_nxt  = 1'b0;
                            end else begin
                                phase_nxt = 1'b1;
                            end
                        end
                    end else if (scl_fall) begin
                        // Pointer moved at the ACK rise, so read data has had time to settle.
                        phase_nxt = 1'b0;
                        state_nxt = RD_DATA;
                        shreg_nxt = {data_from_reg[6:0], 1'b0};
                        oe_nxt    = ~data_from_reg[7];
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    oe_nxt    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_register_bridge.sv
// Bench for i2c_register_bridge: bit-banged I2C master, register file model (addr ^ 0x5A),
// write scoreboard, table of write transactions plus read, abort, reset and glitch sequences.
module tb_i2c_register_bridge;

    localparam int Q        = 10;
    localparam int NO_SPIKE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_out_en;
    logic [7:0] reg_addr;
    logic [7:0] data_to_reg;
    logic       write_en;
    logic [7:0] data_from_reg;
    logic       busy;

    assign sda_line = sda_m & ~sda_out_en;

    i2c_register_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .scl_in       (scl_m),
        .sda_in       (sda_line),
        .sda_out_en   (sda_out_en),
        .reg_addr     (reg_addr),
        .data_to_reg  (data_to_reg),
        .write_en     (write_en),
        .data_from_reg(data_from_reg),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data_from_reg <= reg_addr ^ 8'h5A;

    logic [15:0] wr_log [0:255];
    int          wr_cnt   = 0;
    int          oe_cnt   = 0;
    int          busy_cnt = 0;

    always @(negedge clk) begin
        if (write_en) begin
            wr_log[wr_cnt % 256] <= {reg_addr, data_to_reg};
            wr_cnt <= wr_cnt + 1;
        end
        if (sda_out_en) oe_cnt <= oe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, input logic spike, output logic s);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        s = sda_line;
        if (spike) begin
            scl_m = 1'b0;
            tick(2);
            scl_m = 1'b1;
        end
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int spike_at, output logic ack);
        logic s;
        for (int i = 0; i < 8; i++) clock_bit(b[7-i], i == spike_at, s);
        clock_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, 1'b0, s);
            b = {b[6:0], s};
        end
        clock_bit(~ack, 1'b0, s);
    endtask

    task automatic compare_writes(input int base);
        int n;
        n = wr_cnt - base;
        check("wr_count", n, exp_q.size());
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) break;
            check("wr_addr_data", wr_log[(base + i) % 256], exp_q.pop_front());
        end
        exp_q.delete();
    endtask

    typedef struct packed {
        logic [7:0]      dev;
        logic [7:0]      ptr;
        logic [1:0]      nd;
        logic [2:0][7:0] d;
        logic            ack;
        logic [7:0]      end_ptr;
    } vec_t;

    vec_t vt [6];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          wb;
        int          ob;
        int          bb;
        logic        a;
        logic [7:0]  a8;
        logic [7:0]  rb;
        logic        s;

        vt[0] = '{8'h78, 8'h82, 2'd1, {8'h00, 8'h00, 8'h05}, 1'b1, 8'h83};
        vt[1] = '{8'h78, 8'hFE, 2'd3, {8'h33, 8'h22, 8'h11}, 1'b1, 8'h01};
        vt[2] = '{8'h50, 8'h12, 2'd1, {8'h00, 8'h00, 8'h34}, 1'b0, 8'h01};
        vt[3] = '{8'h78, 8'h10, 2'd0, {8'h00, 8'h00, 8'h00}, 1'b1, 8'h10};
        vt[4] = '{8'h7A, 8'h20, 2'd2, {8'h00, 8'h66, 8'h55}, 1'b0, 8'h10};
        vt[5] = '{8'h78, 8'h7F, 2'd2, {8'h00, 8'h5A, 8'hA5}, 1'b1, 8'h81};

        tick(5);
        rst = 1'b0;
        tick(2);
        check("rst_oe", sda_out_en, 1'b0);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_data", data_to_reg, 8'h00);
        check("rst_we", write_en, 1'b0);
        check("rst_busy", busy, 1'b0);

        for (int v = 0; v < 6; v++) begin
            wb = wr_cnt;
            ob = oe_cnt;
            bb = busy_cnt;
            exp_q.delete();
            i2c_start();
            write_byte(vt[v].dev, NO_SPIKE, a);
            check("dev_ack", a, vt[v].ack);
            write_byte(vt[v].ptr, NO_SPIKE, a);
            check("ptr_ack", a, vt[v].ack);
            for (int i = 0; i < int'(vt[v].nd); i++) begin
                write_byte(vt[v].d[i], NO_SPIKE, a);
                check("data_ack", a, vt[v].ack);
                a8 = vt[v].ptr + 8'(i);
                if (vt[v].ack) exp_q.push_back({a8, vt[v].d[i]});
            end
            i2c_stop();
            tick(4);
            compare_writes(wb);
            check("end_ptr", reg_addr, vt[v].end_ptr);
            check("oe_used", oe_cnt != ob, vt[v].ack);
            check("busy_seen", busy_cnt != bb, vt[v].ack);
            check("busy_idle", busy, 1'b0);
        end

        // Pointer write, repeated START, four reads ending in NACK.
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h78, NO_SPIKE, a);
        check("rd_dev_w_ack", a, 1'b1);
        write_byte(8'hA0, NO_SPIKE, a);
        check("rd_ptr_ack", a, 1'b1);
        i2c_start();
        write_byte(8'h79, NO_SPIKE, a);
        check("rd_dev_r_ack", a, 1'b1);
        check("rd_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            read_byte(i < 3, rb);
            a8 = 8'hA0 + 8'(i);
            check("rd_data", rb, a8 ^ 8'h5A);
        end
        check("rd_busy_nack", busy, 1'b0);
        check("rd_oe_nack", sda_out_en, 1'b0);
        i2c_stop();
        tick(4);
        compare_writes(wb);
        check("rd_end_ptr", reg_addr, 8'hA4);

        // STOP in the middle of a data byte.
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h78, NO_SPIKE, a);
        write_byte(8'h40, NO_SPIKE, a);
        check("abort_ptr_ack", a, 1'b1);
        for (int i = 0; i < 4; i++) clock_bit(i[0] == 1'b0, 1'b0, s);
        i2c_stop();
        tick(2);
        check("abort_oe", sda_out_en, 1'b0);
        check("abort_busy", busy, 1'b0);
        compare_writes(wb);
        check("abort_ptr", reg_addr, 8'h40);
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h78, NO_SPIKE, a);
        write_byte(8'h41, NO_SPIKE, a);
        write_byte(8'h99, NO_SPIKE, a);
        check("abort_next_ack", a, 1'b1);
        exp_q.push_back({8'h41, 8'h99});
        i2c_stop();
        tick(4);
        compare_writes(wb);
        check("abort_next_ptr", reg_addr, 8'h42);

        // Reset while the bridge drives a zero data bit.
        i2c_start();
        write_byte(8'h78, NO_SPIKE, a);
        write_byte(8'h5A, NO_SPIKE, a);
        i2c_start();
        write_byte(8'h79, NO_SPIKE, a);
        check("rstrd_ack", a, 1'b1);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b0, s);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        check("rstrd_oe_before", sda_out_en, 1'b1);
        rst = 1'b1;
        tick(1);
        check("rstrd_oe", sda_out_en, 1'b0);
        check("rstrd_busy", busy, 1'b0);
        check("rstrd_ptr", reg_addr, 8'h00);
        rst = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
        i2c_stop();
        tick(4);
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h78, NO_SPIKE, a);
        write_byte(8'h30, NO_SPIKE, a);
        write_byte(8'h44, NO_SPIKE, a);
        check("rstrd_next_ack", a, 1'b1);
        exp_q.push_back({8'h30, 8'h44});
        i2c_stop();
        tick(4);
        compare_writes(wb);
        check("rstrd_next_ptr", reg_addr, 8'h31);

        // Two-clk low spike on SCL during the MSB of a data byte.
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h78, NO_SPIKE, a);
        write_byte(8'h10, NO_SPIKE, a);
        write_byte(8'h81, 0, a);
`ifdef I2C_BRIDGE_GLITCH_FILTER_EN
        check("glitch_ack", a, 1'b1);
        exp_q.push_back({8'h10, 8'h81});
`else
        check("glitch_ack", a, 1'b0);
        exp_q.push_back({8'h10, 8'hC0});
`endif
        i2c_stop();
        tick(4);
        compare_writes(wb);
        check("glitch_ptr", reg_addr, 8'h11);
        check("glitch_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_register_bridge.md
# i2c_register_bridge

I2C slave protocol engine for the configuration path between the on-board controller and the FPGA register file. It recovers bytes from the external SCL/SDA lines, matches the device address, and maintains an auto-incrementing register pointer. It sits directly upstream of the register file: it drives register address, write data and a one-cycle write strobe, and serialises the register file's read data back onto SDA.

## Interface

Parameters:
- DEVICE_ADDRESS, 7'h3C, 7-bit I2C slave address matched after START.
- FILTER_LEN, 4, consecutive equal samples required to accept an SCL/SDA level change (used only when the glitch filter is compiled in; legal range 2..15).

Ports:
- clk  in  1  system clock; must be at least 20x the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL pin level (asynchronous).
- sda_in  in  1  raw SDA pin level (asynchronous).
- sda_out_en  out  1  1 = pull SDA low (open drain); 0 = release.
- reg_addr  out  8  register pointer presented to the register file.
- data_to_reg  out  8  write data to the register file.
- write_en  out  1  one-clk write strobe; reg_addr/data_to_reg valid while high.
- data_from_reg  in  8  registered read data; valid 1 clk after reg_addr changes.
- busy  out  1  high from accepted START with address match until STOP or NACK.

## Operation

- Input conditioning: 2-flop synchroniser on scl_in and sda_in; edge flags scl_rise, scl_fall, sda_rise, sda_fall derived from the conditioned levels.
- START = sda_fall while SCL high; STOP = sda_rise while SCL high. Both are recognised in every state and take priority over bit events in the same clk. START (including repeated START) → DEV_ADDR, bit counter cleared. STOP → IDLE.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits on scl_rise, MSB first.
  - ACK_DEV: acknowledge on an address match; on a mismatch, go to WAIT_STOP without driving SDA.
  - WR_PTR: first byte after address+W loads the pointer.
  - WR_DATA: each following byte pulses write_en.
  - ACK_W: ACK slot for write bytes.
  - RD_DATA: shift data_from_reg out MSB first.
  - RD_ACK: sample the master ACK/NACK.
  - WAIT_STOP: ignore bus until START/STOP.
- Write: on the 8th-bit scl_rise of a data byte, data_to_reg is updated. write_en pulses for exactly 1 clk on the following scl_fall, with reg_addr = current pointer. The pointer increments on the clk after the pulse.
- Every write byte and the pointer byte are ACKed. No NACK is generated for writes.
- Read: on the scl_fall ending the ACK_DEV slot, the shift register loads data_from_reg. The pointer has been stable for at least one SCL half-period.
  - Master ACK (SDA low at the 9th scl_rise): increment the pointer, then reload from data_from_reg at the next scl_fall.
  - Master NACK: increment the pointer, release SDA, go to WAIT_STOP.
- Pointer arithmetic: 8-bit, wraps 8'hFF → 8'h00 for both reads and writes. The pointer is preserved across transactions, so a write of only the pointer byte followed by a repeated-START read reads from that pointer.
- sda_out_en changes only on the clk after scl_fall, giving hold time. It is released in IDLE, WAIT_STOP, on STOP/START, and after ACK slots.

## Timing

- Reset values: sda_out_en=0, reg_addr=8'h00, data_to_reg=8'h00, write_en=0, busy=0, state IDLE, bit counter 0.
- Reset mid-transfer: the bridge immediately releases SDA and returns to IDLE. It ignores the bus until the next START.
- Pin-to-edge latency: 3 clk (synchroniser + edge register), plus FILTER_LEN clk when the filter is compiled in.
- write_en: at most one pulse per received data byte; never asserted during address, pointer or read phases.
- data_from_reg is sampled at least 2 clk after the last reg_addr change.
- busy rises on the clk ACK_DEV is entered with a match, and falls on the clk STOP, NACK or mismatch is detected.

## Configuration

- I2C_BRIDGE_GLITCH_FILTER_EN defined: after the synchroniser, each line's conditioned level changes only after FILTER_LEN consecutive equal samples. This suppresses spikes shorter than FILTER_LEN clk.
- Not defined: the conditioned level equals the synchroniser output; FILTER_LEN is ignored.

## Test plan

- Write S,0x78,0x82,0x05,P → ACKs on all three bytes; one write_en pulse with reg_addr=0x82, data_to_reg=0x05; pointer ends at 0x83.
- Burst write S,0x78,0xFE,0x11,0x22,0x33,P → write_en at addresses 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33 (wrap-around).
- Pointer set then Sr read: S,0x78,0xA0,Sr,0x79, read 4 bytes with ACK,ACK,ACK,NACK, P. The model returns addr^0x5A, so SDA must carry 0xFA, 0xFB, 0xF8, 0xF9. No write_en pulses; pointer ends at 0xA4.
- Address mismatch S,0x50,... → sda_out_en stays 0 for the whole transfer; busy stays 0; no write_en.
- STOP injected after bit 4 of a data byte, and rst asserted mid-read → no write_en, SDA released within 1 clk, next valid transaction completes normally.
- With I2C_BRIDGE_GLITCH_FILTER_EN and FILTER_LEN=4: a 2-clk low spike on SCL during a data bit produces no extra bit shift. Without the macro, the same spike corrupts the byte.
